keypad_scan: RTL and testbench

Matrix-keypad front end for the code lock. It scans a 4x4 active-low key matrix and debounces each full scan frame. Each clean key press becomes one single-cycle event on the lock's `din`/`confirm`/`cancel` inputs. It sits directly upstream of `lock` and drives those inputs from the same `clk`/`clr`.

---
 rtl/keypad_scan.sv | 209 ++++++++++++++++++++
 tb/tb_keypad_scan.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with frame-level debounce.
// Each clean press becomes one single-cycle din/confirm/cancel event for the code lock.
module keypad_scan #(
    parameter int CLK_DIV      = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] din,
    output logic       din_valid,
    output logic       confirm,
    output logic       cancel,
    output logic       key_err
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_t;
    typedef enum logic [1:0] {WAIT_REL, IDLE, HELD} state_t;

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [3:0]       sync1, sync2;
    logic [3:0]       cap0, cap1, cap2;
    logic [3:0]       pressed_col;
    logic [15:0]      frame_now;
    logic [4:0]       ones;
    logic [3:0]       cur_key, prev_key;
    cls_t             cur_kind, prev_kind;
    logic [CNT_W-1:0] deb_cnt, next_cnt;
    logic             dwell_end, frame_done, same_cls, stable;
    state_t           state_q, state_d;
    logic             fire;
    logic [3:0]       ev_digit;
    logic             ev_is_digit, ev_confirm, ev_cancel;

    assign dwell_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign frame_done  = dwell_end && (col_idx == 2'd3);
    assign pressed_col = ~sync2;
    assign col_out     = ~(4'b0001 << col_idx);

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1 <= 4'b1111;
            sync2 <= 4'b1111;
        end else begin
            sync1 <= row_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            div_cnt <= '0;
            col_idx <= 2'd0;
        end else if (dwell_end) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Columns 0-2 are latched; column 3 is taken live so the frame closes on its own sample.
    always_ff @(posedge clk) begin
        if (clr) begin
            cap0 <= '0;
            cap1 <= '0;
            cap2 <= '0;
        end else if (dwell_end) begin
            case (col_idx)
                2'd0:    cap0 <= pressed_col;
                2'd1:    cap1 <= pressed_col;
                2'd2:    cap2 <= pressed_col;
                default: ;
            endcase
        end
    end

    always_comb begin
        frame_now = '0;
        for (int r = 0; r < 4; r++) begin
            frame_now[4*r + 0] = cap0[r];
            frame_now[4*r + 1] = cap1[r];
            frame_now[4*r + 2] = cap2[r];
            frame_now[4*r + 3] = pressed_col[r];
        end
        ones    = '0;
        cur_key = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame_now[i]) begin
                ones    = ones + 5'd1;
                cur_key = 4'(i);
            end
        end
        if (ones == 5'd0) begin
            cur_kind = CLS_NONE;
        end else if (ones == 5'd1) begin
            cur_kind = CLS_SINGLE;
        end else begin
            cur_kind = CLS_MULTI;
        end
        if (ones != 5'd1) begin
            cur_key = '0;
        end
    end

    always_comb begin
        same_cls = (cur_kind == prev_kind) && (cur_key == prev_key);
        if (!same_cls) begin
            next_cnt = CNT_W'(1);
        end else if (deb_cnt == CNT_W'(DEBOUNCE_CNT)) begin
            next_cnt = deb_cnt;
        end else begin
            next_cnt = deb_cnt + CNT_W'(1);
        end
        stable = (next_cnt == CNT_W'(DEBOUNCE_CNT));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            prev_kind <= CLS_NONE;
            prev_key  <= '0;
            deb_cnt   <= '0;
        end else if (frame_done) begin
            prev_kind <= cur_kind;
            prev_key  <= cur_key;
            deb_cnt   <= next_cnt;
        end
    end

    // Key index 4r+c to event; A-D fall through to no event.
    always_comb begin
        ev_digit    = 4'd0;
        ev_is_digit = 1'b0;
        ev_confirm  = 1'b0;
        ev_cancel   = 1'b0;
        case (cur_key)
            4'd0:  begin ev_digit = 4'd1; ev_is_digit = 1'b1; end
            4'd1:  begin ev_digit = 4'd2; ev_is_digit = 1'b1; end
            4'd2:  begin ev_digit = 4'd3; ev_is_digit = 1'b1; end
            4'd4:  begin ev_digit = 4'd4; ev_is_digit = 1'b1; end
            4'd5:  begin ev_digit = 4'd5; ev_is_digit = 1'b1; end
            4'd6:  begin ev_digit = 4'd6; ev_is_digit = 1'b1; end
            4'd8:  begin ev_digit = 4'd7; ev_is_digit = 1'b1; end
            4'd9:  begin ev_digit = 4'd8; ev_is_digit = 1'b1; end
            4'd10: begin ev_digit = 4'd9; ev_is_digit = 1'b1; end
            4'd13: begin ev_digit = 4'd0; ev_is_digit = 1'b1; end
            4'd12: ev_cancel  = 1'b1;
            4'd14: ev_confirm = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= WAIT_REL;
        end else begin
            state_q <= state_d;
        end
    end

    // A release is always required between events, so HELD only leaves on stable NONE.
    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        if (frame_done && stable) begin
            case (state_q)
                WAIT_REL: begin
                    if (cur_kind == CLS_NONE) state_d = IDLE;
                end
                IDLE: begin
                    if (cur_kind == CLS_SINGLE) begin
                        state_d = HELD;
                        fire    = 1'b1;
                    end else if (cur_kind == CLS_MULTI) begin
                        state_d = HELD;
                    end
                end
                HELD: begin
                    if (cur_kind == CLS_NONE) state_d = IDLE;
                end
                default: state_d = WAIT_REL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            din       <= 4'd0;
            din_valid <= 1'b0;
            confirm   <= 1'b0;
            cancel    <= 1'b0;
            key_err   <= 1'b0;
        end else begin
            din_valid <= fire && ev_is_digit;
            din       <= (fire && ev_is_digit) ? ev_digit : 4'd0;
            confirm   <= fire && ev_confirm;
            cancel    <= fire && ev_cancel;
            if (frame_done) begin
                key_err <= stable && (cur_kind == CLS_MULTI);
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a keypad matrix model drives row_in from col_out,
// and a frame-level model of the debounce/press rules predicts every output cycle.
module tb_keypad_scan;

    localparam int CLK_DIV = 4;
    localparam int DEB     = 3;
    localparam int F       = 4 * CLK_DIV;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  row_in, col_out, din;
    logic        din_valid, confirm, cancel, key_err;
    logic [15:0] pressed = '0;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    // Reference model state: class -1 = none, -2 = multi, else key index
    int m_prev, m_cnt, m_state;
    bit m_err;
    localparam int ST_WAIT = 0, ST_IDLE = 1, ST_HELD = 2;
    string keymap = "123A456B789C*0#D";

    int obs_ev[$];
    int obs_cyc[$];

    keypad_scan #(.CLK_DIV(CLK_DIV), .DEBOUNCE_CNT(DEB)) dut (
        .clk(clk), .clr(clr), .row_in(row_in), .col_out(col_out),
        .din(din), .din_valid(din_valid), .confirm(confirm),
        .cancel(cancel), .key_err(key_err)
    );

    always #5 clk = ~clk;

    // A pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if ((pressed[4*r +: 4] & ~col_out) != 4'b0000) row_in[r] = 1'b0;
        end
    end

    function automatic logic [15:0] kb(input int idx);
        logic [15:0] one;
        one = 16'd1;
        return one << idx;
    endfunction

    function automatic int classify(input logic [15:0] k);
        int n;
        n = $countones(k);
        if (n == 0) return -1;
        if (n > 1) return -2;
        for (int i = 0; i < 16; i++) if (k[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_prev  = -1;
        m_cnt   = 0;
        m_state = ST_WAIT;
        m_err   = 1'b0;
    endtask

    // Returns expected {din_valid, din[3:0], confirm, cancel, key_err} for the event cycle.
    function automatic logic [7:0] model_frame(input logic [15:0] keys);
        int  cls;
        bit  stable;
        bit  ev;
        byte ch;
        logic [7:0] res;
        cls = classify(keys);
        if (cls == m_prev) m_cnt = (m_cnt < DEB) ? m_cnt + 1 : DEB;
        else m_cnt = 1;
        m_prev = cls;
        stable = (m_cnt == DEB);
        m_err  = stable && (cls == -2);
        ev = 1'b0;
        if (stable) begin
            if (m_state == ST_WAIT && cls == -1) m_state = ST_IDLE;
            else if (m_state == ST_IDLE && cls >= 0) begin m_state = ST_HELD; ev = 1'b1; end
            else if (m_state == ST_IDLE && cls == -2) m_state = ST_HELD;
            else if (m_state == ST_HELD && cls == -1) m_state = ST_IDLE;
        end
        res = {7'b0, m_err};
        if (ev) begin
            ch = keymap[cls];
            if (ch >= "0" && ch <= "9") res = {1'b1, 4'(ch - "0"), 2'b00, m_err};
            else if (ch == "#") res = {5'b0, 1'b1, 1'b0, m_err};
            else if (ch == "*") res = {5'b0, 1'b0, 1'b1, m_err};
        end
        return res;
    endfunction

    // Holds a key set for one full frame and checks every cycle against the model.
    task automatic do_frame(input logic [15:0] keys);
        logic [7:0] exp_out, got;
        logic [3:0] exp_col, one;
        one = 4'b0001;
        pressed = keys;
        for (int i = 0; i < F; i++) begin
            @(posedge clk); #1;
            cycle++;
            if (i == F - 1) exp_out = model_frame(keys);
            else exp_out = {7'b0, m_err};
            got = {din_valid, din, confirm, cancel, key_err};
            tests++;
            if (got !== exp_out) begin
                fails++;
                $display("[TB] FAIL outputs cyc %0d: got %b required %b", cycle, got, exp_out);
            end
            exp_col = ~(one << (((i + 1) / CLK_DIV) % 4));
            tests++;
            if (col_out !== exp_col) begin
                fails++;
                $display("[TB] FAIL col_out cyc %0d: got %b required %b", cycle, col_out, exp_col);
            end
            if (din_valid) begin obs_ev.push_back(int'(din)); obs_cyc.push_back(cycle); end
            if (confirm)   begin obs_ev.push_back(10); obs_cyc.push_back(cycle); end
            if (cancel)    begin obs_ev.push_back(11); obs_cyc.push_back(cycle); end
        end
    endtask

    task automatic frames(input logic [15:0] keys, input int n);
        for (int j = 0; j < n; j++) do_frame(keys);
    endtask

    task automatic check_events(input string name, input int exp_q[$]);
        tests++;
        if (obs_ev.size() != exp_q.size()) begin
            fails++;
            $display("[TB] FAIL %s count: got %0d required %0d", name, obs_ev.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++;
                if (obs_ev[i] != exp_q[i]) begin
                    fails++;
                    $display("[TB] FAIL %s event %0d: got %0d required %0d", name, i, obs_ev[i], exp_q[i]);
                end
            end
        end
        obs_ev.delete();
        obs_cyc.delete();
    endtask

    task automatic apply_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        cycle++;
        model_reset();
        tests++;
        if ({col_out, din, din_valid, confirm, cancel, key_err} !== {4'b1110, 4'b0, 4'b0}) begin
            fails++;
            $display("[TB] FAIL reset state: got col=%b din=%h v=%b c=%b x=%b e=%b required col=1110 rest 0",
                     col_out, din, din_valid, confirm, cancel, key_err);
        end
    endtask

    task automatic test_reset();
        pressed = kb(0);
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        model_reset();
        tests++;
        if ({col_out, din, din_valid, confirm, cancel, key_err} !== {4'b1110, 4'b0, 4'b0}) begin
            fails++;
            $display("[TB] FAIL reset state: got col=%b din=%h v=%b c=%b x=%b e=%b required col=1110 rest 0",
                     col_out, din, din_valid, confirm, cancel, key_err);
        end
    endtask

    task automatic test_first_press();
        frames(kb(0), 4);
        frames('0, DEB);
        frames(kb(0), 4);
        frames('0, DEB);
        check_events("first_press", '{1});
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 5; k++) begin
            frames(kb(5), 2);
            frames('0, 1);
        end
        frames('0, DEB);
        check_events("bounce", '{});
        frames(kb(5), 4);
        frames('0, DEB);
        check_events("bounce_then_hold", '{5});
    endtask

    task automatic test_special_keys();
        frames(kb(14), 4); frames('0, DEB);
        frames(kb(12), 4); frames('0, DEB);
        frames(kb(15), 4); frames('0, DEB);
        frames(kb(13), 4); frames('0, DEB);
        check_events("special_keys", '{10, 11, 0});
    endtask

    task automatic test_multi();
        frames(kb(1) | kb(2), DEB);
        tests++;
        if (key_err !== 1'b1) begin
            fails++;
            $display("[TB] FAIL key_err set: got %b required 1", key_err);
        end
        frames(kb(1), 4);
        tests++;
        if (key_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL key_err clear: got %b required 0", key_err);
        end
        frames('0, DEB);
        check_events("multi_no_event", '{});
        frames(kb(1), 4); frames('0, DEB);
        check_events("multi_repress", '{2});
    endtask

    task automatic test_clr_midframe();
        frames(kb(8), 4);
        pressed = kb(8);
        repeat (7) @(posedge clk);
        #1;
        cycle += 7;
        apply_clr();
        obs_ev.delete();
        obs_cyc.delete();
        frames(kb(8), 4);
        frames('0, DEB);
        frames(kb(8), 4);
        frames('0, DEB);
        check_events("clr_midframe", '{7});
    endtask

    task automatic test_back_to_back();
        int seq[5];
        seq = '{0, 1, 2, 4, 14};
        foreach (seq[s]) begin
            frames(kb(seq[s]), 4);
            frames('0, DEB);
        end
        if (obs_cyc.size() == 5) begin
            for (int i = 1; i < 5; i++) begin
                tests++;
                if (obs_cyc[i] - obs_cyc[i-1] < 2 * DEB * F) begin
                    fails++;
                    $display("[TB] FAIL spacing %0d: got %0d required >= %0d", i, obs_cyc[i] - obs_cyc[i-1], 2 * DEB * F);
                end
            end
        end
        check_events("sequence", '{1, 2, 3, 4, 10});
    endtask

    task automatic test_random();
        logic [15:0] keys;
        int sel, a, b;
        for (int n = 0; n < 70; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) keys = '0;
            else if (sel < 8) keys = kb($urandom_range(0, 15));
            else begin
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                keys = kb(a) | kb(b);
            end
            frames(keys, $urandom_range(1, 5));
        end
        frames('0, DEB);
        obs_ev.delete();
        obs_cyc.delete();
    endtask

    initial begin
        clr = 1'b1;
        test_reset();
        test_first_press();
        test_bounce();
        test_special_keys();
        test_multi();
        test_clr_midframe();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
